// File: rtl/llc_snoop_responder.sv
// Snoop-side responder for the LLC: looks up a snooped line in the 8-way tag/MESI
// store, issues any L1 recall/invalidate messages, writes back MESI, returns the snoop result.
module llc_snoop_responder #(
    parameter int ASSOC    = 8,
    parameter int TAG_W    = 11,
    parameter int INDEX_W  = 15,
    parameter int OFFSET_W = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_snp_valid,
    output logic                        o_snp_ready,
    input  logic [2:0]                  i_snp_op,
    input  logic [31:0]                 i_snp_addr,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic [1:0]                  o_res,
    output logic                        o_ts_rd_en,
    output logic [INDEX_W-1:0]          o_ts_index,
    input  logic [ASSOC*(2+TAG_W)-1:0]  i_ts_rd_data,
    output logic                        o_ts_wr_en,
    output logic [2:0]                  o_ts_wr_way,
    output logic [1:0]                  o_ts_wr_mesi,
    output logic                        o_l1_msg_valid,
    output logic [2:0]                  o_l1_msg,
    output logic [31:0]                 o_l1_addr,
    input  logic                        i_l1_ack,
    output logic                        o_err
);
    // state   | meaning
    // IDLE    | ready for a snoop; op and line address latched on accept
    // LOOKUP  | tag-store set read issued
    // DECIDE  | set data valid; hit detection and action table registered
    // GETL    | GETLINE to L1, waiting for ack
    // INVL    | INVALIDATELINE to L1, waiting for ack
    // UPDATE  | one-cycle MESI write-back
    // RESP    | snoop result held until consumed

    localparam int LINE_W   = 32 - OFFSET_W;
    localparam int WAY_BITS = 2 + TAG_W;

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    localparam logic [1:0] RES_NOHIT = 2'd0;
    localparam logic [1:0] RES_HIT   = 2'd1;
    localparam logic [1:0] RES_HITM  = 2'd2;

    localparam logic [2:0] L1_NONE    = 3'd0;
    localparam logic [2:0] L1_GETLINE = 3'd1;
    localparam logic [2:0] L1_INVLINE = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DECIDE,
        S_GETL,
        S_INVL,
        S_UPDATE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [LINE_W-1:0]   r_line;
    logic [1:0]          r_res;
    logic                r_need_inv;
    logic                r_need_upd;
    logic [2:0]          r_way;
    logic [1:0]          r_new_mesi;

    logic [ASSOC-1:0]    w_match;
    logic                w_hit;
    logic                w_multi;
    logic [2:0]          w_hit_way;
    logic [1:0]          w_hit_mesi;
    logic [1:0]          w_res;
    logic                w_get;
    logic                w_inv;
    logic                w_upd;
    logic                w_bad;
    logic [1:0]          w_new_mesi;
    logic                w_unused;

    assign w_unused = ^i_snp_addr[OFFSET_W-1:0];

    always_comb begin
        w_match = '0;
        for (int w = 0; w < ASSOC; w++) begin
            w_match[w] = (i_ts_rd_data[w*WAY_BITS +: TAG_W] == r_line[LINE_W-1 -: TAG_W]) &&
                         (i_ts_rd_data[w*WAY_BITS+TAG_W +: 2] != MESI_I);
        end
    end

    // Scan from the top so the lowest-numbered matching way wins.
    always_comb begin
        w_hit_way  = '0;
        w_hit_mesi = MESI_I;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_hit_way  = 3'(w);
                w_hit_mesi = i_ts_rd_data[w*WAY_BITS+TAG_W +: 2];
            end
        end
    end

    assign w_hit   = |w_match;
    assign w_multi = |(w_match & (w_match - {{(ASSOC-1){1'b0}}, 1'b1}));

    always_comb begin
        w_res      = RES_NOHIT;
        w_get      = 1'b0;
        w_inv      = 1'b0;
        w_new_mesi = w_hit_mesi;
        w_bad      = w_multi;
        case (r_op)
            OP_READ: begin
                if (w_hit) begin
                    case (w_hit_mesi)
                        MESI_M: begin
                            w_res      = RES_HITM;
                            w_get      = 1'b1;
                            w_new_mesi = MESI_S;
                        end
                        MESI_E: begin
                            w_res      = RES_HIT;
                            w_new_mesi = MESI_S;
                        end
                        default: w_res = RES_HIT;
                    endcase
                end
            end
            OP_RWIM: begin
                if (w_hit) begin
                    w_inv      = 1'b1;
                    w_new_mesi = MESI_I;
                    if (w_hit_mesi == MESI_M) begin
                        w_res = RES_HITM;
                        w_get = 1'b1;
                    end else begin
                        w_res = RES_HIT;
                    end
                end
            end
            OP_INV: begin
                if (w_hit) begin
                    if (w_hit_mesi == MESI_S) begin
                        w_res      = RES_HIT;
                        w_inv      = 1'b1;
                        w_new_mesi = MESI_I;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            OP_WRITE: begin
                if (w_hit) begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_upd = w_hit && (w_new_mesi != w_hit_mesi);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        o_snp_ready    = 1'b0;
        o_ts_rd_en     = 1'b0;
        o_ts_wr_en     = 1'b0;
        o_l1_msg_valid = 1'b0;
        o_l1_msg       = L1_NONE;
        o_res_valid    = 1'b0;
        o_err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_snp_ready = 1'b1;
                if (i_snp_valid) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                o_ts_rd_en = 1'b1;
                w_next     = S_DECIDE;
            end
            S_DECIDE: begin
                o_err = w_bad;
                if (w_get) begin
                    w_next = S_GETL;
                end else if (w_inv) begin
                    w_next = S_INVL;
                end else if (w_upd) begin
                    w_next = S_UPDATE;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_GETL: begin
                o_l1_msg_valid = 1'b1;
                o_l1_msg       = L1_GETLINE;
                if (i_l1_ack) begin
                    if (r_need_inv) begin
                        w_next = S_INVL;
                    end else if (r_need_upd) begin
                        w_next = S_UPDATE;
                    end else begin
                        w_next = S_RESP;
                    end
                end
            end
            S_INVL: begin
                o_l1_msg_valid = 1'b1;
                o_l1_msg       = L1_INVLINE;
                if (i_l1_ack) begin
                    w_next = r_need_upd ? S_UPDATE : S_RESP;
                end
            end
            S_UPDATE: begin
                o_ts_wr_en = 1'b1;
                w_next     = S_RESP;
            end
            S_RESP: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op       <= '0;
            r_line     <= '0;
            r_res      <= RES_NOHIT;
            r_need_inv <= 1'b0;
            r_need_upd <= 1'b0;
            r_way      <= '0;
            r_new_mesi <= MESI_I;
        end else begin
            if ((r_state == S_IDLE) && i_snp_valid) begin
                r_op   <= i_snp_op;
                r_line <= i_snp_addr[31:OFFSET_W];
            end
            if (r_state == S_DECIDE) begin
                r_res      <= w_res;
                r_need_inv <= w_inv;
                r_need_upd <= w_upd;
                r_way      <= w_hit_way;
                r_new_mesi <= w_new_mesi;
            end
        end
    end

    assign o_res        = r_res;
    assign o_ts_index   = r_line[INDEX_W-1:0];
    assign o_ts_wr_way  = r_way;
    assign o_ts_wr_mesi = r_new_mesi;
    assign o_l1_addr    = {r_line, {OFFSET_W{1'b0}}};

endmodule
